conv_encoder_param: RTL and testbench

//  Parametrised rate-1/N feed-forward convolutional encoder for the PRML/Viterbi datapath.

---
 rtl/conv_encoder_param.sv | 82 ++++++++
 tb/tb_conv_encoder_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_encoder_param.sv
// conv_encoder_param: rate-1/N feed-forward convolutional encoder, serialised output, optional zero-tail termination
module conv_encoder_param #(
  parameter int K = 3,
  parameter int N = 2,
  parameter GEN = 6'b111_011,
  parameter bit TERMINATE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_bit,
  output logic out_last
);
  localparam int IW = $clog2(N);
  localparam int TW = K > 2 ? $clog2(K - 1) : 1;
  localparam logic [IW-1:0] ILAST = IW'(N - 1);
  localparam logic [TW-1:0] TLAST = TW'(K - 2);
  if (K < 2 || N < 2 || $bits(GEN) != N * K) begin : g_bad_params
    $error("conv_encoder_param: need K>=2, N>=2 and a GEN of N*K bits");
  end
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  state_t state, state_n;
  logic [K-2:0] s, s_n;
  logic [N-1:0] cw, cw_n;
  logic [IW-1:0] idx, idx_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [K-1:0] w;
  logic last_cw, last_n, tail_pend, fire, wrap, accept, zload, load, b;
  assign tail_pend = TERMINATE && last_cw;
  assign fire = state != IDLE && out_ready;
  assign wrap = fire && idx == ILAST;
  // a new bit may enter on the same cycle the previous codeword drains
  assign in_ready = state == IDLE || (state == DATA && wrap && !tail_pend);
  assign accept = in_valid && in_ready;
  assign zload = wrap && (state == DATA ? tail_pend : tcnt != TLAST);
  assign load = accept || zload;
  assign b = accept && in_bit;
  // window: w[K-1] is the current bit, lower bits step back in time (s[0] newest)
  always_comb begin
    w = '0;
    w[K-1] = b;
    for (int i = 0; i < K - 1; i++) w[K-2-i] = s[i];
    s_n = s;
    cw_n = cw;
    if (load) begin
      s_n[0] = b;
      for (int i = 1; i < K - 1; i++) s_n[i] = s[i-1];
      for (int j = 0; j < N; j++) cw_n[j] = ^(w & GEN[(N-j)*K-1 -: K]);
    end
  end
  assign state_n = load ? (zload ? TAIL : DATA) : wrap ? IDLE : state;
  assign idx_n = (load || wrap) ? '0 : fire ? idx + 1'b1 : idx;
  assign tcnt_n = zload ? (state == TAIL ? tcnt + 1'b1 : '0) : tcnt;
  assign last_n = accept ? in_last : last_cw;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      cw <= '0;
      idx <= '0;
      tcnt <= '0;
      last_cw <= 1'b0;
      out_valid <= 1'b0;
      out_bit <= 1'b0;
      out_last <= 1'b0;
    end else begin
      state <= state_n;
      s <= s_n;
      cw <= cw_n;
      idx <= idx_n;
      tcnt <= tcnt_n;
      last_cw <= last_n;
      out_valid <= state_n != IDLE;
      out_bit <= cw_n[idx_n];
      out_last <= idx_n == ILAST && (state_n == TAIL ? tcnt_n == TLAST : state_n == DATA && !TERMINATE && last_n);
    end
endmodule

// File: tb/tb_conv_encoder_param.sv
// tb_conv_encoder_param: three encoder configurations checked against a convolution-sum model
module tb_conv_encoder_param;
  logic clock = 1'b0, reset = 1'b0;
  logic [2:0] iv = '0, ib = '0, il = '0, ordy = '0;
  logic [2:0] ir, ov, ob, ol;
  int vectors = 0, miscompares = 0;
  int kk[3] = '{3, 3, 4};
  int nn[3] = '{2, 2, 3};
  logic [11:0] gg[3] = '{12'b111_011, 12'b111_011, 12'b1111_1101_1011};
  logic tm[3] = '{1'b1, 1'b0, 1'b1};
  logic [7:0] hist[3] = '{8'd0, 8'd0, 8'd0};
  logic [1:0] eq[$];
  logic [63:0] coll;
  int ncoll;

  always #5 clock = ~clock;

  conv_encoder_param u0 (.clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_bit(ob[0]), .out_last(ol[0]));
  conv_encoder_param #(.TERMINATE(1'b0)) u1 (.clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_bit(ib[1]), .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_bit(ob[1]), .out_last(ol[1]));
  conv_encoder_param #(.K(4), .N(3), .GEN(12'b1111_1101_1011)) u2 (.clock(clock), .reset(reset), .in_valid(iv[2]),
    .in_ready(ir[2]), .in_bit(ib[2]), .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_bit(ob[2]),
    .out_last(ol[2]));

  // code bit j = XOR over delays t of tap(G_j, K-1-t) * x[n-t]
  task automatic push_cw(input int d, input logic bi, input logic lst);
    logic [11:0] g;
    logic [8:0] x;
    logic p;
    x = {hist[d], bi};
    for (int j = 0; j < nn[d]; j++) begin
      g = gg[d] >> ((nn[d] - 1 - j) * kk[d]);
      p = 1'b0;
      for (int t = 0; t < kk[d]; t++) p ^= g[kk[d]-1-t] & x[t];
      eq.push_back({p, lst && j == nn[d] - 1});
    end
    hist[d] = x[7:0];
  endtask

  // mode 0: random valid/ready; 1: valid held, ready high; 2: valid held, ready 1,0,0,1; 3: random valid, ready high
  task automatic run_frame(input int d, input int len, input logic [15:0] bits, input int mode);
    int sent = 0, cyc = 0, last_acc = 0;
    logic pv = 1'b0, pr = 1'b0, pb = 1'b0, pl = 1'b0;
    logic [1:0] e;
    coll = '0;
    ncoll = 0;
    while ((sent < len || eq.size() > 0) && cyc < 500) begin
      @(negedge clock);
      ordy[d] = (mode == 1 || mode == 3) ? 1'b1 : mode == 2 ? 1'(cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 3) != 0);
      iv[d] = sent < len && (mode == 1 || mode == 2 || $urandom_range(0, 2) != 0);
      ib[d] = bits[sent];
      il[d] = sent == len - 1;
      #1;
      vectors++;
      if (ov[d] !== (eq.size() > 0)) begin
        miscompares++;
        $display("FAIL valid d=%0d cyc=%0d got %b want %b", d, cyc, ov[d], eq.size() > 0);
      end
      if (pv && !pr) begin
        vectors++;
        if ({ob[d], ol[d]} !== {pb, pl}) begin
          miscompares++;
          $display("FAIL stall_hold d=%0d cyc=%0d got %b%b want %b%b", d, cyc, ob[d], ol[d], pb, pl);
        end
      end
      if (ov[d] && ordy[d] && eq.size() > 0) begin
        e = eq.pop_front();
        vectors++;
        if ({ob[d], ol[d]} !== e) begin
          miscompares++;
          $display("FAIL code_bit d=%0d bit#%0d got bit/last %b/%b want %b/%b", d, ncoll, ob[d], ol[d], e[1], e[0]);
        end
        coll = {coll[62:0], ob[d]};
        ncoll++;
      end
      if (iv[d] && ir[d]) begin
        if (mode == 1 && sent > 0) begin
          vectors++;
          if (cyc - last_acc !== nn[d]) begin
            miscompares++;
            $display("FAIL accept_spacing d=%0d got %0d want %0d", d, cyc - last_acc, nn[d]);
          end
        end
        last_acc = cyc;
        push_cw(d, ib[d], !tm[d] && il[d]);
        if (tm[d] && il[d]) for (int t = 1; t < kk[d]; t++) push_cw(d, 1'b0, t == kk[d] - 1);
        sent++;
      end
      pv = ov[d];
      pr = ordy[d];
      pb = ob[d];
      pl = ol[d];
      cyc++;
    end
    iv[d] = 1'b0;
    if (cyc >= 500) begin
      miscompares++;
      $display("FAIL timeout d=%0d sent %0d of %0d, %0d bits pending", d, sent, len, eq.size());
      eq.delete();
    end
    @(negedge clock);
    #1;
    vectors++;
    if (ov[d] !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after d=%0d got out_valid %b want 0", d, ov[d]);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    #1;
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if ({ov[d], ob[d], ol[d], ir[d]} !== 4'b0001) begin
        miscompares++;
        $display("FAIL reset_state d=%0d got v/b/l/rdy %b%b%b%b want 0001", d, ov[d], ob[d], ol[d], ir[d]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    run_frame(0, 4, 16'b1101, 3);
    vectors++;
    if (ncoll != 12 || coll[11:0] !== 12'b10_11_01_01_00_11) begin
      miscompares++;
      $display("FAIL basic_frame got %0d bits %b want 12 bits 101101010011", ncoll, coll[11:0]);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(0, 4, 16'b1101, 1);
    vectors++;
    if (ncoll != 12 || coll[11:0] !== 12'b10_11_01_01_00_11) begin
      miscompares++;
      $display("FAIL b2b_frame got %0d bits %b want 12 bits 101101010011", ncoll, coll[11:0]);
    end
  endtask

  task automatic test_backpressure();
    run_frame(0, 4, 16'b1101, 2);
    vectors++;
    if (ncoll != 12 || coll[11:0] !== 12'b10_11_01_01_00_11) begin
      miscompares++;
      $display("FAIL stall_frame got %0d bits %b want 12 bits 101101010011", ncoll, coll[11:0]);
    end
  endtask

  task automatic test_no_terminate();
    run_frame(1, 4, 16'b1101, 3);
    vectors++;
    if (ncoll != 8 || coll[7:0] !== 8'b10_11_01_01) begin
      miscompares++;
      $display("FAIL noterm_frame got %0d bits %b want 8 bits 10110101", ncoll, coll[7:0]);
    end
    run_frame(1, 2, 16'b00, 0);
    vectors++;
    if (ncoll != 4 || coll[3:0] !== 4'b00_11) begin
      miscompares++;
      $display("FAIL noterm_carry got %0d bits %b want 4 bits 0011", ncoll, coll[3:0]);
    end
  endtask

  task automatic test_reset_midword();
    int seen = 0, cyc = 0;
    iv[0] = 1'b1;
    ib[0] = 1'b1;
    il[0] = 1'b0;
    ordy[0] = 1'b1;
    while (seen < 3 && cyc < 20) begin
      @(negedge clock);
      #1;
      if (ov[0]) seen++;
      if (ir[0]) ib[0] = 1'b0;
      cyc++;
    end
    @(negedge clock);
    #1;
    iv[0] = 1'b0;
    vectors++;
    if (ov[0] !== 1'b1 || seen != 3) begin
      miscompares++;
      $display("FAIL midword_setup got out_valid %b after %0d bits want 1 after 3", ov[0], seen);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({ov[0], ob[0], ol[0], ir[0]} !== 4'b0001) begin
      miscompares++;
      $display("FAIL async_reset got v/b/l/rdy %b%b%b%b want 0001", ov[0], ob[0], ol[0], ir[0]);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int d = 0; d < 3; d++) hist[d] = '0;
    eq.delete();
    run_frame(0, 1, 16'b1, 3);
    vectors++;
    if (ncoll != 6 || coll[5:4] !== 2'b10) begin
      miscompares++;
      $display("FAIL post_reset got %0d bits, first %b want 6 bits, first 10", ncoll, coll[5:4]);
    end
  endtask

  task automatic test_k4();
    run_frame(2, 1, 16'b1, 3);
    vectors++;
    if (ncoll != 12 || coll[11:3] !== 9'b111_110_101) begin
      miscompares++;
      $display("FAIL k4_frame got %0d bits %b want 12 bits starting 111110101", ncoll, coll[11:0]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      for (int d = 0; d < 3; d++) run_frame(d, $urandom_range(1, 8), 16'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_no_terminate();
    test_reset_midword();
    test_k4();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
